// File: rtl/thor2023_wb_scratchpad.sv
// thor2023_wb_scratchpad: 128-bit Wishbone responder backed by an on-chip scratchpad RAM.
// Ports: clk_i/rst_ni clock and async active-low reset; cyc_i/stb_i/we_i/sel_i/adr_i/dat_i
// request; cti_i/bte_i/blen_i burst type, wrap mode and beat count; tid_i request id;
// ack_o/next_o/rty_o/err_o responses; tid_o echoed id; dat_o read data.
module thor2023_wb_scratchpad #(
  parameter logic [31:0] BASE_ADR       = 32'hFFFC0000,
  parameter int          DEPTH          = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  input  logic [15:0]  sel_i,
  input  logic [31:0]  adr_i,
  input  logic [127:0] dat_i,
  input  logic [2:0]   cti_i,
  input  logic [1:0]   bte_i,
  input  logic [5:0]   blen_i,
  input  logic [7:0]   tid_i,
  output logic         ack_o,
  output logic         next_o,
  output logic         rty_o,
  output logic         err_o,
  output logic [7:0]   tid_o,
  output logic [127:0] dat_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {INIT, IDLE, RD, WR, BURST_RD, BURST_WR, ERR, WAIT_NEG} state_t;
  localparam state_t RST_ST = CLEAR_ON_RESET ? INIT : IDLE;

  state_t         state, nxt;
  logic [AW-1:0]  clr_cnt, idx, a_idx, m, step, ram_adr;
  logic [5:0]     beat, blen_q;
  logic [1:0]     bte_q;
  logic           rty_q, hit, burst, ovf, burst_ack, ram_we;
  logic [127:0]   ram [DEPTH];
  logic [127:0]   rdata;
  logic           unused_lsb;

  assign unused_lsb = ^adr_i[3:0];
  assign hit   = cyc_i & stb_i & (adr_i[31:AW+4] == BASE_ADR[31:AW+4]);
  assign a_idx = adr_i[AW+3:4];
  assign burst = cti_i == 3'b010;
  assign ovf   = ({1'b0, a_idx} + (AW+1)'(blen_i)) > (AW+1)'(DEPTH - 1);
  // wrap bursts only advance the low index bits; linear uses a full-width mask
  assign m     = bte_q == 2'd1 ? AW'(3) : bte_q == 2'd2 ? AW'(7) : bte_q == 2'd3 ? AW'(15) : '1;
  assign step  = (idx & ~m) | ((idx + AW'(1)) & m);

  // dropping cyc_i withdraws the burst ack in the same cycle
  assign burst_ack = cyc_i & (state == BURST_RD || state == BURST_WR);
  assign ack_o  = state == RD || state == WR || burst_ack;
  assign next_o = burst_ack & (beat != blen_q);
  assign err_o  = state == ERR;
  assign rty_o  = rty_q;
  assign dat_o  = (state == RD || (state == BURST_RD && cyc_i)) ? rdata : '0;

  // read bursts prefetch the next beat's line so beats come back to back
  assign ram_adr = state == INIT ? clr_cnt : state == IDLE ? a_idx : state == BURST_RD ? step : idx;
  assign ram_we  = state == INIT || (state == IDLE && hit && we_i && !burst) ||
                   (state == BURST_WR && cyc_i && stb_i);

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 16; i++)
      if (ram_we && (state == INIT || sel_i[i]))
        ram[ram_adr][8*i +: 8] <= state == INIT ? 8'h00 : dat_i[8*i +: 8];
    rdata <= ram[ram_adr];
  end

  always_comb begin
    nxt = state;
    case (state)
      INIT:     if (clr_cnt == '1) nxt = IDLE;
      IDLE:     if (hit) nxt = burst ? ((bte_i == 2'd0 && ovf) ? ERR : we_i ? BURST_WR : BURST_RD)
                               : we_i ? WR : RD;
      RD, WR, ERR: nxt = WAIT_NEG;
      WAIT_NEG: if (!stb_i || !cyc_i) nxt = IDLE;
      default:  nxt = !cyc_i ? IDLE : (beat == blen_q || cti_i == 3'b111) ? WAIT_NEG : state;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RST_ST;
      clr_cnt <= '0;
      idx     <= '0;
      beat    <= '0;
      blen_q  <= '0;
      bte_q   <= '0;
      tid_o   <= '0;
      rty_q   <= 1'b0;
    end else begin
      state <= nxt;
      rty_q <= state == INIT && hit;
      if (state == INIT) clr_cnt <= clr_cnt + AW'(1);
      if (state == IDLE && hit) begin
        tid_o  <= tid_i;
        idx    <= a_idx;
        beat   <= '0;
        blen_q <= blen_i;
        bte_q  <= bte_i;
      end
      if (burst_ack) begin
        idx  <= step;
        beat <= beat + 6'd1;
      end
    end
  end
endmodule
